seq_shift_add_multiplier: RTL and testbench



---
 rtl/seq_shift_add_multiplier_if.sv | 11 +
 rtl/seq_shift_add_multiplier.sv | 54 +++++
 tb/tb_seq_shift_add_multiplier.sv | 124 ++++++++++++
 3 files changed

// File: rtl/seq_shift_add_multiplier_if.sv
// seq_shift_add_multiplier_if: start/done handshake and operand/product bus for the shift-add multiplier.
interface seq_shift_add_multiplier_if #(parameter int WIDTH = 4);
  logic               start;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   mplier;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] product;
  modport master (output start, mcand, mplier, input busy, done, product);
  modport slave  (input start, mcand, mplier, output busy, done, product);
endinterface

// File: rtl/seq_shift_add_multiplier.sv
// seq_shift_add_multiplier: unsigned multiplier doing one ripple-carry conditional add and right shift per clock.
module seq_shift_add_multiplier #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input logic clk,
  input logic rst_n,
  seq_shift_add_multiplier_if.slave bus
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] CALC = 1'b1;
  logic [0:0]       state;
  logic [WIDTH-1:0] a, q, p_hi, addend, sum;
  logic [WIDTH:0]   c;
  logic [CNT_W-1:0] cnt;
  assign addend = q[0] ? a : '0;
  assign c[0] = 1'b0;
  // Explicit ripple chain so the carry-out lands in the product MSB instead of being dropped.
  for (genvar i = 0; i < WIDTH; i++) begin : g_rca
    assign sum[i]   = p_hi[i] ^ addend[i] ^ c[i];
    assign c[i+1]   = (p_hi[i] & addend[i]) | (c[i] & (p_hi[i] ^ addend[i]));
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      a           <= '0;
      q           <= '0;
      p_hi        <= '0;
      cnt         <= '0;
      bus.busy    <= 1'b0;
      bus.done    <= 1'b0;
      bus.product <= '0;
    end else if (state == IDLE) begin
      bus.done <= 1'b0;
      if (bus.start) begin
        a        <= bus.mcand;
        q        <= bus.mplier;
        p_hi     <= '0;
        cnt      <= '0;
        bus.busy <= 1'b1;
        state    <= CALC;
      end
    end else begin
      {p_hi, q} <= {c[WIDTH], sum, q[WIDTH-1:1]};
      cnt       <= cnt + 1'b1;
      if (cnt == CNT_W'(WIDTH - 1)) begin
        bus.product <= {c[WIDTH], sum, q[WIDTH-1:1]};
        bus.done    <= 1'b1;
        bus.busy    <= 1'b0;
        state       <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// tb_seq_shift_add_multiplier: vector table, handshake corner cases and a full operand sweep against a*b.
module tb_seq_shift_add_multiplier;
  localparam int W = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  logic [2*W-1:0] last_prod;
  seq_shift_add_multiplier_if #(.WIDTH(W)) bus ();
  seq_shift_add_multiplier #(.WIDTH(W), .CNT_W(3)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #100 clk = ~clk;
  typedef struct {logic [W-1:0] a; logic [W-1:0] b; logic [2*W-1:0] p;} vec_t;
  vec_t vecs[6];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic [2*W-1:0] exp, input bit noise);
    int k;
    @(negedge clk);
    bus.start = 1'b1; bus.mcand = x; bus.mplier = y;
    @(negedge clk);
    bus.start = 1'b0;
    chk("accept_busy", 32'(bus.busy), 32'd1);
    chk("product_held", 32'(bus.product), 32'(last_prod));
    k = 0;
    while (!bus.done && k < W + 3) begin
      if (noise && k < W) begin
        bus.start = 1'($urandom_range(0, 1));
        bus.mcand = W'($urandom); bus.mplier = W'($urandom);
      end else bus.start = 1'b0;
      @(negedge clk);
      k++;
    end
    bus.start = 1'b0;
    chk("done_latency", 32'(k), 32'(W));
    chk("product", 32'(bus.product), 32'(exp));
    chk("busy_at_done", 32'(bus.busy), 32'd0);
    last_prod = exp;
    @(negedge clk);
    chk("done_one_cycle", 32'(bus.done), 32'd0);
  endtask
  initial begin
    int pulses;
    int off, mul;
    bus.start = 1'b0; bus.mcand = '0; bus.mplier = '0;
    last_prod = '0;
    vecs[0] = '{4'd13, 4'd11, 8'h8F};
    vecs[1] = '{4'd15, 4'd15, 8'hE1};
    vecs[2] = '{4'd0,  4'd9,  8'h00};
    vecs[3] = '{4'd1,  4'd1,  8'h01};
    vecs[4] = '{4'd9,  4'd0,  8'h00};
    vecs[5] = '{4'd8,  4'd15, 8'h78};
    #30;
    chk("reset_busy", 32'(bus.busy), 32'd0);
    chk("reset_done", 32'(bus.done), 32'd0);
    chk("reset_product", 32'(bus.product), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    foreach (vecs[i]) do_op(vecs[i].a, vecs[i].b, vecs[i].p, 1'b0);
    // back-to-back: start held high across done
    @(negedge clk);
    bus.start = 1'b1; bus.mcand = 4'd3; bus.mplier = 4'd5;
    repeat (W + 1) @(negedge clk);
    chk("b2b_first_done", 32'(bus.done), 32'd1);
    chk("b2b_first_prod", 32'(bus.product), 32'h0F);
    bus.mcand = 4'd6; bus.mplier = 4'd7;
    @(negedge clk);
    bus.start = 1'b0;
    chk("b2b_reaccept_busy", 32'(bus.busy), 32'd1);
    chk("b2b_reaccept_done", 32'(bus.done), 32'd0);
    repeat (W) @(negedge clk);
    chk("b2b_second_done", 32'(bus.done), 32'd1);
    chk("b2b_second_prod", 32'(bus.product), 32'h2A);
    last_prod = 8'h2A;
    @(negedge clk);
    // start pulsed mid-CALC is ignored
    bus.start = 1'b1; bus.mcand = 4'd7; bus.mplier = 4'd9;
    @(negedge clk); bus.start = 1'b0;
    @(negedge clk); bus.start = 1'b1; bus.mcand = 4'd2; bus.mplier = 4'd2;
    @(negedge clk); bus.start = 1'b0;
    pulses = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.done) pulses++;
    end
    chk("ignore_pulses", 32'(pulses), 32'd1);
    chk("ignore_prod", 32'(bus.product), 32'h3F);
    last_prod = 8'h3F;
    // async reset mid-operation
    @(negedge clk);
    bus.start = 1'b1; bus.mcand = 4'd10; bus.mplier = 4'd10;
    @(negedge clk); bus.start = 1'b0;
    repeat (2) @(negedge clk);
    #20 rst_n = 1'b0;
    #1;
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_product", 32'(bus.product), 32'd0);
    last_prod = '0;
    @(negedge clk); rst_n = 1'b1;
    pulses = 0;
    repeat (W + 2) begin
      @(negedge clk);
      if (bus.done) pulses++;
    end
    chk("rst_no_done", 32'(pulses), 32'd0);
    do_op(4'd4, 4'd4, 8'h10, 1'b0);
    // every operand pair, shuffled order, with noise on the inputs while busy
    off = int'($urandom_range(0, 255));
    mul = 2 * int'($urandom_range(0, 127)) + 1;
    for (int i = 0; i < 256; i++) begin
      int idx;
      logic [W-1:0] x, y;
      idx = (i * mul + off) & 255;
      x = W'(idx >> W); y = W'(idx);
      do_op(x, y, (2*W)'(int'(x) * int'(y)), 1'b1);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
